// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if -- received-byte stream and error strobes of the UART receiver.
//   rx_data    [7:0] byte at FIFO head, meaningful while rx_valid=1
//   rx_valid         FIFO not empty
//   rx_ready         consumer accepts head byte on rx_valid&rx_ready at a clk edge
//   frame_err        one-cycle pulse, stop bit sampled low
//   overrun          one-cycle pulse, good byte dropped because FIFO full
//   parity_err       one-cycle pulse, even-parity mismatch (0 when parity disabled)
// master: receiver side; slave: consumer side.
interface uart_rx_frontend_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend -- 8N1 UART receiver with a small circular byte FIFO.
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   uart_rx  asynchronous serial line, idle high
//   rx_bus   uart_rx_frontend_if.master: rx_data/rx_valid/rx_ready stream
//            plus frame_err/overrun/parity_err one-cycle strobes
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (even parity bit
// after data bit 7, mismatching bytes are dropped with a parity_err pulse).
module uart_rx_frontend #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_rx,
    uart_rx_frontend_if.master         rx_bus
);
    localparam int unsigned CPB = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(CPB);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CPB - 1);
    localparam logic [PW:0]   DEPTH_C     = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          push, fe_set;
    logic          frame_err_q, overrun_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, pop, do_push, ov_set;

    // Two-flop synchronizer, idle (1) out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[0], uart_rx};
    end
    assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d, pe_set, parity_err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            frame_err_q <= fe_set;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= pe_set;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        push    = 1'b0;
        fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        pe_set    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d = DATA;
                    cnt_d   = FULL_RELOAD;
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;   // glitch shorter than half a bit
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    cnt_d = FULL_RELOAD;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_bad_d = rx_s ^ (^sh_q);
                    cnt_d     = FULL_RELOAD;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    fe_set  = 1'b1;
                    state_d = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                end else if (par_bad_q) begin
                    pe_set  = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte FIFO; a pop in the same cycle frees the slot for a push when full.
    assign full    = (count == DEPTH_C);
    assign pop     = rx_bus.rx_valid & rx_bus.rx_ready;
    assign do_push = push & (~full | pop);
    assign ov_set  = push & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun_q <= ov_set;
            if (do_push) begin
                mem[wr_ptr] <= sh_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rx_bus.rx_data   = mem[rd_ptr];
    assign rx_bus.rx_valid  = (count != '0);
    assign rx_bus.frame_err = frame_err_q;
    assign rx_bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_err = parity_err_q;
`else
    assign rx_bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frontend.sv
module tb_uart_rx_frontend;
    logic clk = 1'b0;
    logic reset;
    logic uart_rx;

    uart_rx_frontend_if bus ();

    uart_rx_frontend #(
        .CLK_HZ    (100000000),
        .BAUD      (10000000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .uart_rx(uart_rx),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    localparam int BIT_NS = 100;

    // Model: bytes that must come out, in order, and pulses still owed.
    logic [7:0] exp_q[$];
    logic [7:0] popped[$];
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int valid_cycles = 0;
    int errors = 0, checks = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_pulse(input string name, input logic now, input logic prev, inout int owed);
        checks++;
        if (now && prev) begin
            errors++;
            $display("FAIL %s: pulse longer than one cycle (got 1 expected 0)", name);
        end else if (now && owed == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse (got 1 expected 0)", name);
        end else if (now) begin
            owed--;
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) valid_cycles++;
            check("valid_without_expected_byte", {31'b0, bus.rx_valid && exp_q.size() == 0}, 32'd0);
            if (bus.rx_valid && bus.rx_ready && exp_q.size() > 0) begin
                check("pop_data", {24'b0, bus.rx_data}, {24'b0, exp_q[0]});
                popped.push_back(bus.rx_data);
                void'(exp_q.pop_front());
            end
            check_pulse("frame_err", bus.frame_err, fe_prev, exp_fe);
            check_pulse("overrun", bus.overrun, ov_prev, exp_ov);
            check_pulse("parity_err", bus.parity_err, pe_prev, exp_pe);
            fe_prev = bus.frame_err;
            ov_prev = bus.overrun;
            pe_prev = bus.parity_err;
        end else begin
            fe_prev = 1'b0;
            ov_prev = 1'b0;
            pe_prev = 1'b0;
        end
    end

    // Drive one frame; the model records what the receiver must do with it.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        if (!stop_bit) exp_fe++;
        else if (par_flip) exp_pe++;
        else if (!bus.rx_ready && exp_q.size() >= 4) exp_ov++;
        else exp_q.push_back(b);
        uart_rx = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #BIT_NS;
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^b) ^ par_flip;
        #BIT_NS;
`endif
        uart_rx = stop_bit;
        #BIT_NS;
        if (!stop_bit) #50;
        uart_rx = 1'b1;
        #200;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 bus.rx_ready = r;
    endtask

    task automatic drain_and_settle(input string name);
        int n;
        set_ready(1'b1);
        n = 0;
        while ((exp_q.size() != 0 || exp_fe != 0 || exp_ov != 0 || exp_pe != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        check({name, "_pulses_seen"}, exp_fe + exp_ov + exp_pe, 0);
    endtask

    initial begin
        reset = 1'b1;
        uart_rx = 1'b1;
        bus.rx_ready = 1'b1;
        #1;
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_flags", {bus.frame_err, bus.overrun, bus.parity_err}, 0);
        #19 reset = 1'b0;
        #100;

        // Single byte with consumer always ready.
        popped.delete();
        valid_cycles = 0;
        send_frame(8'hA5, 1'b1, 1'b0);
        drain_and_settle("t1");
        check("t1_count", popped.size(), 1);
        if (popped.size() == 1) check("t1_byte", popped[0], 8'hA5);
        check("t1_valid_cycles", valid_cycles, 1);

        // Fill the FIFO with the consumer stalled; fifth byte overruns.
        popped.delete();
        set_ready(1'b0);
        for (int k = 1; k <= 5; k++) send_frame(k[7:0], 1'b1, 1'b0);
        check("t2_overrun_owed", exp_ov, 0);
        drain_and_settle("t2");
        check("t2_count", popped.size(), 4);
        for (int k = 0; k < 4 && k < popped.size(); k++)
            check("t2_order", popped[k], k + 1);

        // Stop bit low: one frame_err, byte discarded, next byte fine.
        popped.delete();
        valid_cycles = 0;
        send_frame(8'h3C, 1'b0, 1'b0);
        check("t3_valid_after_ferr", valid_cycles, 0);
        send_frame(8'h7E, 1'b1, 1'b0);
        drain_and_settle("t3");
        check("t3_count", popped.size(), 1);
        if (popped.size() == 1) check("t3_byte", popped[0], 8'h7E);

        // 30 ns glitch on idle line.
        valid_cycles = 0;
        uart_rx = 1'b0;
        #30 uart_rx = 1'b1;
        #400;
        check("t4_glitch_valid", valid_cycles, 0);

        // Reset in the middle of 0xFF, after data bit 3.
        uart_rx = 1'b0;
        #BIT_NS;
        uart_rx = 1'b1;
        #(4 * BIT_NS);
        reset = 1'b1;
        #1;
        check("t5_rst_rx_valid", bus.rx_valid, 0);
        check("t5_rst_rx_data", bus.rx_data, 0);
        check("t5_rst_flags", {bus.frame_err, bus.overrun, bus.parity_err}, 0);
        #19 reset = 1'b0;
        #200;
        popped.delete();
        send_frame(8'h5A, 1'b1, 1'b0);
        drain_and_settle("t5");
        check("t5_count", popped.size(), 1);
        if (popped.size() == 1) check("t5_byte", popped[0], 8'h5A);

`ifdef UART_RX_PARITY_EN
        // Wrong parity dropped, correct parity accepted.
        popped.delete();
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        drain_and_settle("t6");
        check("t6_count", popped.size(), 1);
        if (popped.size() == 1) check("t6_byte", popped[0], 8'h03);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before 2 ms");
        $fatal(1);
    end
endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter: CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter: BAUD, default 115200, line rate in bit/s; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 4).
REQ-003 Parameter: FIFO_DEPTH, default 4, received-byte buffer depth, power of two, 2..16.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 uart_rx  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 under REQ-026).
REQ-007 rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
REQ-008 rx_valid  output  1  FIFO not empty.
REQ-009 rx_ready  input  1  consumer accepts head byte when rx_valid&rx_ready at a clk edge.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: good byte dropped because FIFO full.
REQ-012 parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN).

Function
REQ-013 uart_rx passes through a 2-flop synchronizer (set to 1 on reset); all logic uses the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, PARITY (present only with UART_RX_PARITY_EN), STOP, WAIT_IDLE.
REQ-015 IDLE -> START on synchronized line low; bit counter loads CLKS_PER_BIT/2 - 1.
REQ-016 START: at mid-bit, line low -> DATA with counter reloaded to CLKS_PER_BIT-1; line high -> IDLE (glitch rejected, no flags).
REQ-017 DATA: 8 samples, one per CLKS_PER_BIT cycles at bit centre, shifted in LSB first; after bit 7 -> PARITY or STOP.
REQ-018 STOP: sample at bit centre; high -> byte good, push to FIFO, -> IDLE; low -> frame_err pulse, byte discarded, -> WAIT_IDLE.
REQ-019 WAIT_IDLE -> IDLE only once synchronized line is high (break condition yields exactly one frame_err).
REQ-020 Push occurs on the clock edge after the stop-bit sample; rx_valid rises on that same edge if FIFO was empty.
REQ-021 FIFO: circular, read/write pointers wrap at FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-022 Push when full and no pop in same cycle: byte dropped, FIFO unchanged, overrun pulse.
REQ-023 Simultaneous push and pop when full: both occur, no overrun, occupancy unchanged.
REQ-024 Pop when empty is ignored; rx_data holds last value (don't-care to consumer).

Reset
REQ-025 On reset assertion, asynchronously: FSM=IDLE, pointers/occupancy=0, rx_valid=0, rx_data=0, frame_err=overrun=parity_err=0, synchronizer=1; a frame in progress is abandoned with no flags; first frame after release must begin with a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: when defined, one even-parity bit follows data bit 7 (PARITY state, sampled at bit centre); mismatch -> parity_err pulse with the stop sample, byte discarded, no push; when undefined, no PARITY state, 10-bit frames, parity_err constant 0.

Verification (CLK_HZ=100000000, BAUD=10000000, CLKS_PER_BIT=10, FIFO_DEPTH=4)
REQ-027 Reset 20 ns, send 0xA5 8N1, rx_ready=1 -> rx_valid 1 cycle with rx_data=0xA5, no flags.
REQ-028 rx_ready=0, send 0x01..0x05 -> first four buffered, overrun pulse once at fifth stop; then rx_ready=1 pops 0x01,0x02,0x03,0x04 in order.
REQ-029 Send 0x3C with stop bit forced low, line returned high 50 ns later -> exactly one frame_err pulse, rx_valid stays 0, next 0x7E received correctly.
REQ-030 30 ns low glitch on idle line -> no state change beyond START, no flags, rx_valid stays 0.
REQ-031 Assert reset mid-byte (after bit 3 of 0xFF) -> all outputs 0 immediately; after release send 0x5A -> 0x5A received.
REQ-032 With UART_RX_PARITY_EN: send 0x03 with parity bit 1 -> parity_err pulse, no push; with parity bit 0 -> 0x03 received.
